ysyx_25020037_wbu_q: RTL and testbench

Parametrised writeback stage between the LSU and the GPR/CSR write ports. It accepts one retiring instruction per cycle over a valid/ready handshake, selects and formats the writeback value (ALU, load with byte/half extraction and sign/zero extension, CSR read, PC+4), and buffers results in a DEPTH-entry FIFO so GPR/CSR backpressure does not stall the LSU. It also exposes the head entry for forwarding and keeps a 64-bit retired-instruction counter.

---
 rtl/ysyx_25020037_wbu_q_pkg.sv | 23 ++
 rtl/ysyx_25020037_wbu_ldfmt.sv | 42 ++++
 rtl/ysyx_25020037_wbu_q.sv | 119 +++++++++++
 tb/tb_ysyx_25020037_wbu_q.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25020037_wbu_q_pkg.sv
// Shared encodings and entry layout for the writeback queue.
package ysyx_25020037_wbu_q_pkg;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_CSR  = 2'd2,
        SRC_PC4  = 2'd3
    } src_sel_e;

    typedef enum logic [1:0] {
        LSIZE_BYTE = 2'd0,
        LSIZE_HALF = 2'd1,
        LSIZE_WORD = 2'd2,
        LSIZE_RSVD = 2'd3
    } lsize_e;

    // Entry layout, MSB to LSB: rd, gpr_we, wdata, csr_we, csr_addr, csr_wdata.
    function automatic int entry_width(input int reg_aw, input int xlen, input int csr_aw);
        return reg_aw + 1 + xlen + 1 + csr_aw + xlen;
    endfunction

endpackage

// File: rtl/ysyx_25020037_wbu_ldfmt.sv
// Load lane select and sign/zero extension from the raw aligned load word.
module ysyx_25020037_wbu_ldfmt
    import ysyx_25020037_wbu_q_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] ldata,
    input  logic [1:0]      lsize,
    input  logic            lunsigned,
    input  logic [1:0]      laddr_lo,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        byte_lane = ldata[7:0];
        case (laddr_lo)
            2'd1:    byte_lane = ldata[15:8];
            2'd2:    byte_lane = ldata[23:16];
            2'd3:    byte_lane = ldata[31:24];
            default: byte_lane = ldata[7:0];
        endcase
    end

    // Halfword selection looks only at address bit 1.
    assign half_lane = laddr_lo[1] ? ldata[31:16] : ldata[15:0];

    always_comb begin
        result = ldata;
        case (lsize_e'(lsize))
            LSIZE_BYTE: result = lunsigned ? {{(XLEN-8){1'b0}}, byte_lane}
                                           : {{(XLEN-8){byte_lane[7]}}, byte_lane};
            LSIZE_HALF: result = lunsigned ? {{(XLEN-16){1'b0}}, half_lane}
                                           : {{(XLEN-16){half_lane[15]}}, half_lane};
            default:    result = ldata;
        endcase
    end

endmodule

// File: rtl/ysyx_25020037_wbu_q.sv
// Writeback stage: formats retiring results and buffers them in a small FIFO
// ahead of the GPR/CSR write ports, with head forwarding and an instret counter.
module ysyx_25020037_wbu_q
    import ysyx_25020037_wbu_q_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 2,
    parameter int REG_AW = 5,
    parameter int CSR_AW = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [REG_AW-1:0]          in_rd,
    input  logic                       in_gpr_we,
    input  logic [1:0]                 in_src_sel,
    input  logic [XLEN-1:0]            in_alu,
    input  logic [XLEN-1:0]            in_ldata,
    input  logic [1:0]                 in_lsize,
    input  logic                       in_lunsigned,
    input  logic [1:0]                 in_laddr_lo,
    input  logic [XLEN-1:0]            in_csr_rdata,
    input  logic [XLEN-1:0]            in_pc,
    input  logic                       in_csr_we,
    input  logic [CSR_AW-1:0]          in_csr_addr,
    input  logic [XLEN-1:0]            in_csr_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [REG_AW-1:0]          out_rd,
    output logic                       out_gpr_we,
    output logic [XLEN-1:0]            out_wdata,
    output logic                       out_csr_we,
    output logic [CSR_AW-1:0]          out_csr_addr,
    output logic [XLEN-1:0]            out_csr_wdata,
    output logic [REG_AW-1:0]          fwd_hit_rd,
    output logic [$clog2(DEPTH):0]     count,
    output logic [63:0]                instret
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = entry_width(REG_AW, XLEN, CSR_AW);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] wb_val;
    logic [EW-1:0]   new_entry;
    logic [EW-1:0]   head;
    logic            push;
    logic            pop;

    ysyx_25020037_wbu_ldfmt #(.XLEN(XLEN)) u_ldfmt (
        .ldata     (in_ldata),
        .lsize     (in_lsize),
        .lunsigned (in_lunsigned),
        .laddr_lo  (in_laddr_lo),
        .result    (load_val)
    );

    always_comb begin
        wb_val = in_alu;
        case (src_sel_e'(in_src_sel))
            SRC_ALU:  wb_val = in_alu;
            SRC_LOAD: wb_val = load_val;
            SRC_CSR:  wb_val = in_csr_rdata;
            SRC_PC4:  wb_val = in_pc + XLEN'(4);
            default:  wb_val = in_alu;
        endcase
    end

    // x0 is never written, so the enable is cleared at enqueue time.
    assign new_entry = {in_rd, in_gpr_we && (in_rd != '0), wb_val,
                        in_csr_we, in_csr_addr, in_csr_wdata};

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head = mem[rd_ptr];
    assign {out_rd, out_gpr_we, out_wdata, out_csr_we, out_csr_addr, out_csr_wdata} = head;
    assign fwd_hit_rd = (out_valid && out_gpr_we) ? out_rd : '0;

    // NOTE: storage holds no reset; out_valid alone qualifies the head data.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            instret <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                instret <= instret + 64'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_wbu_q.sv
// Directed self-checking bench for the writeback queue (default parameters).
module tb_ysyx_25020037_wbu_q;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_gpr_we;
    logic [1:0]  in_src_sel;
    logic [31:0] in_alu;
    logic [31:0] in_ldata;
    logic [1:0]  in_lsize;
    logic        in_lunsigned;
    logic [1:0]  in_laddr_lo;
    logic [31:0] in_csr_rdata;
    logic [31:0] in_pc;
    logic        in_csr_we;
    logic [11:0] in_csr_addr;
    logic [31:0] in_csr_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic        out_gpr_we;
    logic [31:0] out_wdata;
    logic        out_csr_we;
    logic [11:0] out_csr_addr;
    logic [31:0] out_csr_wdata;
    logic [4:0]  fwd_hit_rd;
    logic [1:0]  count;
    logic [63:0] instret;

    int passed = 0;
    int total  = 0;

    ysyx_25020037_wbu_q dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_gpr_we     (in_gpr_we),
        .in_src_sel    (in_src_sel),
        .in_alu        (in_alu),
        .in_ldata      (in_ldata),
        .in_lsize      (in_lsize),
        .in_lunsigned  (in_lunsigned),
        .in_laddr_lo   (in_laddr_lo),
        .in_csr_rdata  (in_csr_rdata),
        .in_pc         (in_pc),
        .in_csr_we     (in_csr_we),
        .in_csr_addr   (in_csr_addr),
        .in_csr_wdata  (in_csr_wdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rd        (out_rd),
        .out_gpr_we    (out_gpr_we),
        .out_wdata     (out_wdata),
        .out_csr_we    (out_csr_we),
        .out_csr_addr  (out_csr_addr),
        .out_csr_wdata (out_csr_wdata),
        .fwd_hit_rd    (fwd_hit_rd),
        .count         (count),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid     = 1'b0;
        in_rd        = '0;
        in_gpr_we    = 1'b0;
        in_src_sel   = 2'd0;
        in_alu       = '0;
        in_ldata     = '0;
        in_lsize     = 2'd0;
        in_lunsigned = 1'b0;
        in_laddr_lo  = 2'd0;
        in_csr_rdata = '0;
        in_pc        = '0;
        in_csr_we    = 1'b0;
        in_csr_addr  = '0;
        in_csr_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [31:0] val);
        in_valid   = 1'b1;
        in_rd      = rd;
        in_gpr_we  = 1'b1;
        in_src_sel = 2'd0;
        in_alu     = val;
    endtask

    task automatic set_load(input logic [1:0] size, input logic uns, input logic [1:0] lo);
        in_valid     = 1'b1;
        in_rd        = 5'd7;
        in_gpr_we    = 1'b1;
        in_src_sel   = 2'd1;
        in_ldata     = 32'h80FF7F01;
        in_lsize     = size;
        in_lunsigned = uns;
        in_laddr_lo  = lo;
    endtask

    initial begin
        idle_inputs();
        out_ready = 1'b0;
        do_reset();

        // Reset state.
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_instret", instret, 64'd0);

        // Load formatting, streamed with out_ready high.
        out_ready = 1'b1;
        set_load(2'd0, 1'b0, 2'd2);
        tick();
        check("lb_valid", 64'(out_valid), 64'd1);
        check("lb_signed", 64'(out_wdata), 64'hFFFFFFFF);
        set_load(2'd0, 1'b1, 2'd2);
        tick();
        check("lbu", 64'(out_wdata), 64'h000000FF);
        set_load(2'd1, 1'b0, 2'd2);
        tick();
        check("lh_signed", 64'(out_wdata), 64'hFFFF80FF);
        set_load(2'd1, 1'b0, 2'd3);
        tick();
        check("lh_lo0_ignored", 64'(out_wdata), 64'hFFFF80FF);
        set_load(2'd0, 1'b0, 2'd1);
        tick();
        check("lb_lane1", 64'(out_wdata), 64'h0000007F);
        set_load(2'd3, 1'b0, 2'd1);
        tick();
        check("lsize3_word", 64'(out_wdata), 64'h80FF7F01);
        idle_inputs();
        tick();
        check("stream_empty", 64'(out_valid), 64'd0);

        // Backpressure with three ALU results.
        do_reset();
        out_ready = 1'b0;
        set_alu(5'd1, 32'h11);
        tick();
        check("bp_count1", 64'(count), 64'd1);
        check("bp_fwd_rd1", 64'(fwd_hit_rd), 64'd1);
        set_alu(5'd2, 32'h22);
        tick();
        check("bp_count2", 64'(count), 64'd2);
        check("bp_full_ready", 64'(in_ready), 64'd0);
        set_alu(5'd3, 32'h33);
        tick();
        check("bp_held_count", 64'(count), 64'd2);
        check("bp_head_rd1", 64'(out_rd), 64'd1);
        check("bp_head_data1", 64'(out_wdata), 64'h11);
        out_ready = 1'b1;
        tick();
        check("bp_head_rd2", 64'(out_rd), 64'd2);
        check("bp_count_after_pop", 64'(count), 64'd1);
        tick();
        check("bp_head_rd3", 64'(out_rd), 64'd3);
        check("bp_head_data3", 64'(out_wdata), 64'h33);
        idle_inputs();
        tick();
        check("bp_drained", 64'(out_valid), 64'd0);
        check("bp_instret", instret, 64'd3);

        // rd=0 with PC+4 wraparound.
        out_ready    = 1'b0;
        in_valid     = 1'b1;
        in_rd        = 5'd0;
        in_gpr_we    = 1'b1;
        in_src_sel   = 2'd3;
        in_pc        = 32'hFFFFFFFC;
        tick();
        idle_inputs();
        check("x0_valid", 64'(out_valid), 64'd1);
        check("x0_gpr_we", 64'(out_gpr_we), 64'd0);
        check("pc4_wrap", 64'(out_wdata), 64'd0);
        check("x0_fwd", 64'(fwd_hit_rd), 64'd0);
        out_ready = 1'b1;
        tick();

        // CSR read/write.
        out_ready    = 1'b0;
        in_valid     = 1'b1;
        in_rd        = 5'd5;
        in_gpr_we    = 1'b1;
        in_src_sel   = 2'd2;
        in_csr_rdata = 32'h1800;
        in_csr_we    = 1'b1;
        in_csr_addr  = 12'h300;
        in_csr_wdata = 32'h88;
        tick();
        idle_inputs();
        check("csr_wdata", 64'(out_wdata), 64'h1800);
        check("csr_we", 64'(out_csr_we), 64'd1);
        check("csr_addr", 64'(out_csr_addr), 64'h300);
        check("csr_new", 64'(out_csr_wdata), 64'h88);
        out_ready = 1'b1;
        tick();

        // Continuous streaming, then reset with one entry queued.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_alu(5'd9, 32'(i));
            tick();
        end
        check("stream_count", 64'(count), 64'd1);
        check("stream_instret", instret, 64'd99);
        check("stream_head", 64'(out_wdata), 64'd99);
        rst = 1'b1;
        tick();
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_instret", instret, 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        idle_inputs();
        tick();
        check("post_rst_empty", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
